prog_loader: RTL
================

# prog_loader

UART-fed boot loader for the processor top. It receives a length-prefixed program image as a byte stream from the UART receiver and writes it word by word into the program RAM write port. While loading it holds the core in reset. It reports ACK or NAK through the transmit buffer, then releases the core. The processor can therefore be reprogrammed without resynthesising the RAM init file.

## Interface
Parameters:
- MEM, 10: byte-address width of memories; program RAM holds 2^(MEM-2) words.
- TIMEOUT, 1_000_000: maximum idle cycles between bytes inside a load before the load is aborted.
- ACK_BYTE, 8'hAA: byte sent on successful load.
- NAK_BYTE, 8'h55: byte sent on error or timeout.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_data  in  8  received byte, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- prog_we  out  1  program RAM write enable, one-cycle pulse.
- prog_addr  out  MEM-2  program RAM word address.
- prog_din  out  32  program RAM write data.
- tx_data  out  8  byte to transmit buffer.
- tx_valid  out  1  transmit request; the byte transfers when tx_valid && tx_ready.
- tx_ready  in  1  transmit buffer can accept a byte.
- core_rstn  out  1  active-low reset to the core; low until the load completes.
- busy  out  1  high in HDR, BODY, RESP.
- err  out  1  sticky; set on NAK, cleared by the next accepted header byte.

## Operation
- The image is a 4-byte little-endian word count N, followed by N 32-bit little-endian words.
- States:
  - IDLE: waiting for the first byte.
  - HDR: collecting count bytes.
  - BODY: collecting words.
  - RESP: sending ACK or NAK.
  - RUN: terminal.
- IDLE -> HDR on rx_valid. That byte is count byte 0.
- HDR, after the 4th byte:
  - N == 0 -> RESP(ACK).
  - N > 2^(MEM-2) -> RESP(NAK).
  - Otherwise -> BODY, with the word address and the remaining count loaded.
- BODY:
  - Bytes shift into a 32-bit assembler; byte 0 lands in bits [7:0].
  - On the 4th byte of a word, prog_we pulses with the assembled word and the current address.
  - The address then increments and the remaining count decrements.
  - After the last write -> RESP(ACK).
- Timeout: in HDR or BODY, a counter resets on every rx_valid. Reaching TIMEOUT -> RESP(NAK). Partial words are discarded. Words already written are left in RAM.
- RESP:
  - tx_valid is held high with ACK_BYTE or NAK_BYTE until tx_ready is seen.
  - After ACK -> RUN.
  - After NAK -> IDLE, with err set.
  - rx_valid is ignored in RESP.
- RUN: core_rstn = 1. All rx bytes are ignored until rstn is asserted.
- Count arithmetic is 32-bit unsigned. The address counter is MEM-2 bits. It never wraps, because N ≤ 2^(MEM-2) is checked beforehand.

## Timing
- Reset values:
  - state = IDLE.
  - prog_we = 0, prog_addr = 0, prog_din = 0.
  - tx_valid = 0, tx_data = 0.
  - core_rstn = 0, busy = 0, err = 0.
  - Internal counters = 0.
- prog_we is registered. It is asserted the cycle after the rx_valid carrying the 4th byte of a word, and is high for exactly 1 cycle.
- prog_addr and prog_din are stable in the prog_we cycle. The address increments the cycle after.
- rx_valid may arrive on consecutive cycles. No byte may be lost in HDR or BODY.
- The RESP transition occurs the cycle after the final write pulse, or after the final header byte when N == 0 or N is oversized.
- tx_valid rises the cycle RESP is entered. It drops the cycle after a cycle with tx_valid && tx_ready. tx_data is constant meanwhile.
- core_rstn rises the cycle after the ACK handshake, and is registered (glitch-free).
- Timeout:
  - The counter counts cycles since the last byte.
  - Exactly TIMEOUT cycles without rx_valid enters RESP on cycle TIMEOUT+1.
  - rx_valid arriving in the same cycle as expiry wins: the byte is accepted and the counter is cleared.
- rstn asserted mid-load aborts immediately with the reset values above. No write is completed.

## Structure
- Package loader_pkg: state enum (IDLE, HDR, BODY, RESP, RUN), ACK/NAK default constants, and the header byte count (4).
- Sub-module word_assembler: byte-lane counter plus 32-bit shift register. Inputs are byte and strobe; outputs are word and word_done pulse. It is shared between the HDR and BODY phases and is cleared on entering HDR and on abort.
- Instantiated in the processor top: rx from the UART receiver, tx muxed into uart_tx_with_buf, prog write port on a dual-port ram_prog, core_rstn ANDed with rstn into core.

## Test plan
- Load with N=3 (bytes 03 00 00 00, then words 0x00000013, 0xDEADBEEF, 0x12345678):
  - 3 prog_we pulses at addr 0/1/2 with those data.
  - Then tx 0xAA.
  - Then core_rstn=1.
- N=0: no prog_we, ACK sent, core_rstn rises.
- Oversized count:
  - N=2^(MEM-2)+1 (MEM=10: 0x101) -> NAK 0x55, err=1, state IDLE, core_rstn stays 0.
  - A following valid load succeeds and clears err.
- Timeout with TIMEOUT=16:
  - Send header N=2, one full word, then 2 bytes, then silence.
  - Expect 1 write, then NAK after 17 idle cycles, with no second write.
- Back-pressure: hold tx_ready=0 for 50 cycles at RESP.
  - tx_valid stays high with tx_data=0xAA.
  - The handshake completes on the first tx_ready cycle; core_rstn rises next cycle.
- rstn pulse mid-BODY, then back-to-back rx_valid every cycle on reload:
  - All outputs are at reset values immediately.
  - The reload writes all words correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;

   typedef enum logic [2:0] {IDLE, HDR, BODY, RESP, RUN} state_t;

   localparam logic [7:0]  ACK_DEF   = 8'hAA;
   localparam logic [7:0]  NAK_DEF   = 8'h55;
   localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler shared by the header and body phases.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr_i,
   input  logic        stb_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        done_o
);

   localparam logic [1:0] LAST_LANE = 2'(HDR_BYTES - 1);

   logic [1:0]  lane_q, lane_d, lane_base;
   logic [31:0] sh_q, sh_d, sh_base;

   // A clear and a strobe in the same cycle start a fresh word with this byte.
   always_comb begin
      lane_base = clr_i ? '0 : lane_q;
      sh_base   = clr_i ? '0 : sh_q;
      lane_d    = lane_base;
      sh_d      = sh_base;
      if (stb_i) begin
         lane_d = lane_base + 2'd1;
         sh_d   = {byte_i, sh_base[31:8]};
      end
      word_o = {byte_i, sh_base[31:8]};
      done_o = stb_i && (lane_base == LAST_LANE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane_q <= '0;
         sh_q   <= '0;
      end else begin
         lane_q <= lane_d;
         sh_q   <= sh_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// UART-fed boot loader: length-prefixed image into program RAM, holding the
// core in reset until an ACK has been handed to the transmit buffer.
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned MEM      = 10,
   parameter int unsigned TIMEOUT  = 1_000_000,
   parameter logic [7:0]  ACK_BYTE = ACK_DEF,
   parameter logic [7:0]  NAK_BYTE = NAK_DEF
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [7:0]     rx_data,
   input  logic           rx_valid,
   output logic           prog_we,
   output logic [MEM-3:0] prog_addr,
   output logic [31:0]    prog_din,
   output logic [7:0]     tx_data,
   output logic           tx_valid,
   input  logic           tx_ready,
   output logic           core_rstn,
   output logic           busy,
   output logic           err
);

   localparam int unsigned AW       = MEM - 2;
   localparam logic [31:0] DEPTH    = 32'(1) << AW;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     din_q, din_d;
   logic            we_q, we_d;
   logic [31:0]     remain_q, remain_d;
   logic [31:0]     tmo_q, tmo_d;
   logic            txv_q, txv_d;
   logic [7:0]      txd_q, txd_d;
   logic            ack_q, ack_d;
   logic            crst_q, crst_d;
   logic            err_q, err_d;

   logic            loading, expire, asm_clr, asm_stb, asm_done;
   logic [31:0]     asm_word;
   logic            resp_go, resp_ack;

   assign loading = (state_q == HDR) || (state_q == BODY);
   // A byte arriving on the expiry cycle wins over the timeout.
   assign expire  = loading && !rx_valid && (tmo_q == TMO_LAST);
   assign asm_clr = (state_q == IDLE) || expire;
   assign asm_stb = rx_valid && ((state_q == IDLE) || loading);

   word_assembler u_asm (
      .clk    (clk),
      .rstn   (rstn),
      .clr_i  (asm_clr),
      .stb_i  (asm_stb),
      .byte_i (rx_data),
      .word_o (asm_word),
      .done_o (asm_done)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      din_d    = din_q;
      we_d     = 1'b0;
      remain_d = remain_q;
      tmo_d    = tmo_q;
      txv_d    = txv_q;
      txd_d    = txd_q;
      ack_d    = ack_q;
      crst_d   = crst_q;
      err_d    = err_q;
      resp_go  = 1'b0;
      resp_ack = 1'b0;

      if (loading) tmo_d = rx_valid ? '0 : tmo_q + 32'd1;

      unique case (state_q)
         IDLE: begin
            if (rx_valid) begin
               state_d = HDR;
               tmo_d   = '0;
               err_d   = 1'b0;
            end
         end
         HDR: begin
            if (expire) begin
               resp_go = 1'b1;
            end else if (asm_done) begin
               if (asm_word == '0) begin
                  resp_go  = 1'b1;
                  resp_ack = 1'b1;
               end else if (asm_word > DEPTH) begin
                  resp_go = 1'b1;
               end else begin
                  state_d  = BODY;
                  remain_d = asm_word;
                  addr_d   = '0;
               end
            end
         end
         BODY: begin
            if (expire) begin
               resp_go = 1'b1;
            end else begin
               if (asm_done) begin
                  we_d  = 1'b1;
                  din_d = asm_word;
               end
               // Address advances after the pulse; held on the last word so it never wraps.
               if (we_q) begin
                  if (remain_q == 32'd1) begin
                     resp_go  = 1'b1;
                     resp_ack = 1'b1;
                  end else begin
                     addr_d   = addr_q + AW'(1);
                     remain_d = remain_q - 32'd1;
                  end
               end
            end
         end
         RESP: begin
            if (txv_q && tx_ready) begin
               txv_d = 1'b0;
               if (ack_q) begin
                  state_d = RUN;
                  crst_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (resp_go) begin
         state_d = RESP;
         txv_d   = 1'b1;
         ack_d   = resp_ack;
         txd_d   = resp_ack ? ACK_BYTE : NAK_BYTE;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
         remain_q <= '0;
         tmo_q    <= '0;
         txv_q    <= 1'b0;
         txd_q    <= '0;
         ack_q    <= 1'b0;
         crst_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
         remain_q <= remain_d;
         tmo_q    <= tmo_d;
         txv_q    <= txv_d;
         txd_q    <= txd_d;
         ack_q    <= ack_d;
         crst_q   <= crst_d;
         err_q    <= err_d;
      end
   end

   assign prog_we   = we_q;
   assign prog_addr = addr_q;
   assign prog_din  = din_q;
   assign tx_valid  = txv_q;
   assign tx_data   = txd_q;
   assign core_rstn = crst_q;
   assign err       = err_q;
   assign busy      = (state_q == HDR) || (state_q == BODY) || (state_q == RESP);

endmodule
